// File: rtl/vector_packer_pkg.sv
// Shared width helpers and the zero-padding rule for vector_packer.
package vector_packer_pkg;

  // Bits needed to hold an element count in 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index a bank of n slots.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A slot survives into the output vector only when it lies inside the frame.
  function automatic logic pad_keep(input int idx, input int len);
    return idx < len;
  endfunction

endpackage

// File: rtl/vector_packer_fill.sv
// Fill bank: collects incoming elements and flags a finished frame with its length.
module vector_packer_fill
  import vector_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BUFFER_SIZE = 16,
  localparam int COUNT_W = count_w(BUFFER_SIZE),
  localparam int IDX_W = idx_w(BUFFER_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               accept,
  input  logic               last,
  input  logic               transfer,
  output logic [WIDTH-1:0]   fill_bank [BUFFER_SIZE-1:0],
  output logic               fill_done,
  output logic [COUNT_W-1:0] fill_len
);

  logic [IDX_W-1:0] fill_cnt;
  logic [IDX_W-1:0] wr_idx;

  // A transfer on the same edge empties the bank, so the new element lands in slot 0.
  assign wr_idx = transfer ? '0 : fill_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) fill_bank[i] <= '0;
      fill_cnt  <= '0;
      fill_done <= 1'b0;
      fill_len  <= '0;
    end else begin
      if (transfer) begin
        fill_done <= 1'b0;
        fill_cnt  <= '0;
      end
      if (accept) begin
        fill_bank[wr_idx] <= data_in;
        if (wr_idx == IDX_W'(BUFFER_SIZE - 1) || last) begin
          fill_done <= 1'b1;
          fill_len  <= COUNT_W'(wr_idx) + COUNT_W'(1);
          fill_cnt  <= '0;
        end else begin
          fill_cnt <= wr_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: fill bank feeds a registered output bank so input
// streams at one element per cycle while a finished vector waits downstream.
module vector_packer
  import vector_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BUFFER_SIZE = 16,
  localparam int COUNT_W = count_w(BUFFER_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               data_in_valid,
  input  logic               data_in_last,
  output logic               data_in_ready,
  output logic [WIDTH-1:0]   data_out [BUFFER_SIZE-1:0],
  output logic [COUNT_W-1:0] data_out_count,
  output logic               data_out_valid,
  input  logic               data_out_ready
);

  // Handshakes on both ports: a transfer happens on an edge where valid && ready;
  // valid never depends on ready, and a raised valid holds with stable payload
  // until that transfer happens.

  logic [WIDTH-1:0]   fill_bank [BUFFER_SIZE-1:0];
  logic [WIDTH-1:0]   out_bank  [BUFFER_SIZE-1:0];
  logic               fill_done;
  logic [COUNT_W-1:0] fill_len;
  logic [COUNT_W-1:0] out_cnt;
  logic               out_valid;
  logic               slot_free;
  logic               transfer;
  logic               accept;

  assign slot_free     = !out_valid || data_out_ready;
  assign data_in_ready = !fill_done || slot_free;
  assign transfer      = fill_done && slot_free;
  assign accept        = data_in_valid && data_in_ready;

  vector_packer_fill #(
    .WIDTH       (WIDTH),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_fill (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .accept    (accept),
    .last      (data_in_last),
    .transfer  (transfer),
    .fill_bank (fill_bank),
    .fill_done (fill_done),
    .fill_len  (fill_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) out_bank[i] <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (transfer) begin
      // Slots past the frame length are zeroed so stale data never leaks out.
      for (int i = 0; i < BUFFER_SIZE; i++)
        out_bank[i] <= pad_keep(i, int'(fill_len)) ? fill_bank[i] : '0;
      out_cnt   <= fill_len;
      out_valid <= 1'b1;
    end else if (out_valid && data_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign data_out       = out_bank;
  assign data_out_count = out_cnt;
  assign data_out_valid = out_valid;

endmodule

// File: tb/tb_vector_packer.sv
// Directed bench for vector_packer (WIDTH=8, BUFFER_SIZE=4): frame table plus
// hand sequences for latency, streaming, backpressure and mid-frame reset.
module tb_vector_packer;

  localparam int WIDTH = 8;
  localparam int BS = 4;
  localparam int CW = 3;
  localparam int VW = CW + BS * WIDTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             data_in_last;
  logic             data_in_ready;
  logic [WIDTH-1:0] data_out [BS-1:0];
  logic [CW-1:0]    data_out_count;
  logic             data_out_valid;
  logic             data_out_ready;

  int checks = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];

  vector_packer #(.WIDTH(WIDTH), .BUFFER_SIZE(BS)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_last   (data_in_last),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_count (data_out_count),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input int cnt, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
    return {CW'(cnt), d, c, b, a};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {data_out_count, data_out[3], data_out[2], data_out[1], data_out[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard: every output handshake must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_vector: got 0x%0h with nothing expected", dut_vec());
      end else begin
        check("vector", 64'(dut_vec()), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver: hold one element until accepted; reports cycles spent waiting
  task automatic push(input logic [7:0] d, input logic l, output int stalls);
    int n;
    n = 0;
    data_in = d;
    data_in_last = l;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!data_in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: element 0x%0h never accepted", d);
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last = 1'b0;
    stalls = n;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] d [4];
    logic       last;
    logic [VW-1:0] exp;
  } frame_t;

  frame_t tbl [5];

  initial begin
    int st;
    int tot;

    tbl[0].n = 2; tbl[0].d = '{8'hA0, 8'hA1, 8'h00, 8'h00}; tbl[0].last = 1'b1;
    tbl[0].exp = pack(2, 8'hA0, 8'hA1, 8'h00, 8'h00);
    tbl[1].n = 1; tbl[1].d = '{8'h7F, 8'h00, 8'h00, 8'h00}; tbl[1].last = 1'b1;
    tbl[1].exp = pack(1, 8'h7F, 8'h00, 8'h00, 8'h00);
    tbl[2].n = 4; tbl[2].d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; tbl[2].last = 1'b1;
    tbl[2].exp = pack(4, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    tbl[3].n = 3; tbl[3].d = '{8'hB0, 8'hB1, 8'hB2, 8'h00}; tbl[3].last = 1'b1;
    tbl[3].exp = pack(3, 8'hB0, 8'hB1, 8'hB2, 8'h00);
    tbl[4].n = 4; tbl[4].d = '{8'hD5, 8'hE6, 8'hF7, 8'h08}; tbl[4].last = 1'b0;
    tbl[4].exp = pack(4, 8'hD5, 8'hE6, 8'hF7, 8'h08);

    rst = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    data_in_last = 1'b0;
    data_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(data_out_valid), 64'd0);
    check("reset_count", 64'(data_out_count), 64'd0);
    check("reset_data", 64'(dut_vec()), 64'd0);
    check("reset_in_ready", 64'(data_in_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // full frame and its one-cycle output latency
    exp_q.push_back(pack(4, 8'h01, 8'h02, 8'h03, 8'h04));
    tot = 0;
    for (int i = 1; i <= 4; i++) begin
      push(8'(i), 1'b0, st);
      tot += st;
    end
    check("latency_not_yet_valid", 64'(data_out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_valid", 64'(data_out_valid), 64'd1);
    check("latency_count", 64'(data_out_count), 64'd4);
    check("full_frame_stalls", 64'(tot), 64'd0);
    wait_drain();

    // frame table: partial, last-first, last-on-final-slot, full
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(tbl[t].exp);
      tot = 0;
      for (int k = 0; k < tbl[t].n; k++) begin
        push(tbl[t].d[k], tbl[t].last && (k == tbl[t].n - 1), st);
        tot += st;
      end
      check("table_stalls", 64'(tot), 64'd0);
      wait_drain();
    end

    // back-to-back stream of three frames with no bubbles
    exp_q.push_back(pack(4, 8'h10, 8'h11, 8'h12, 8'h13));
    exp_q.push_back(pack(4, 8'h14, 8'h15, 8'h16, 8'h17));
    exp_q.push_back(pack(4, 8'h18, 8'h19, 8'h1A, 8'h1B));
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h10 + i), 1'b0, st);
      tot += st;
    end
    check("stream_stalls", 64'(tot), 64'd0);
    wait_drain();

    // backpressure: two frames buffered, then input stalls
    data_out_ready = 1'b0;
    exp_q.push_back(pack(4, 8'h01, 8'h02, 8'h03, 8'h04));
    exp_q.push_back(pack(4, 8'h05, 8'h06, 8'h07, 8'h08));
    exp_q.push_back(pack(2, 8'h09, 8'h0A, 8'h00, 8'h00));
    tot = 0;
    for (int i = 1; i <= 8; i++) begin
      push(8'(i), 1'b0, st);
      tot += st;
    end
    check("bp_fill_stalls", 64'(tot), 64'd0);
    data_in = 8'h09;
    data_in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(data_in_ready), 64'd0);
      check("bp_valid_held", 64'(data_out_valid), 64'd1);
      check("bp_data_held", 64'(dut_vec()), 64'(pack(4, 8'h01, 8'h02, 8'h03, 8'h04)));
    end
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    push(8'h09, 1'b0, st);
    check("bp_release_stalls", 64'(st), 64'd0);
    push(8'h0A, 1'b1, st);
    wait_drain();

    // reset while one vector is waiting and a partial frame is in flight
    data_out_ready = 1'b0;
    push(8'h21, 1'b0, st);
    push(8'h22, 1'b1, st);
    push(8'h55, 1'b0, st);
    push(8'h66, 1'b0, st);
    check("pre_reset_valid", 64'(data_out_valid), 64'd1);
    check("pre_reset_data", 64'(dut_vec()), 64'(pack(2, 8'h21, 8'h22, 8'h00, 8'h00)));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_valid", 64'(data_out_valid), 64'd0);
    check("async_reset_data", 64'(dut_vec()), 64'd0);
    check("async_reset_in_ready", 64'(data_in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    exp_q.push_back(pack(4, 8'h31, 8'h32, 8'h33, 8'h34));
    for (int i = 0; i < 4; i++) push(8'(8'h31 + i), 1'b0, st);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
